// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg                                                            |
// | Shared sizes, typedefs and FSM states for the tag fill controller.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cache_pkg;

    localparam int N_WAYS   = 2;
    localparam int TAG_BITS = 21;
    localparam int N_POW    = 4;
    localparam int SET_BITS = 4;
    localparam int N_SETS   = 1 << SET_BITS;

    typedef logic [SET_BITS-1:0] set_t;
    typedef logic [TAG_BITS-1:0] tag_t;
    typedef logic [N_POW-1:0]    way_t;
    typedef way_t [N_WAYS-1:0]   age_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tag_fill_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tag_fill_ctrl_if                                                     |
// | Miss request, memory fill and completion handshakes.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface tag_fill_ctrl_if;
    import cache_pkg::*;

    logic miss_valid;
    logic miss_ready;
    set_t miss_set;
    tag_t miss_tag;
    logic fill_req_valid;
    logic fill_req_ready;
    set_t fill_req_set;
    tag_t fill_req_tag;
    way_t fill_req_way;
    logic fill_rsp_valid;
    logic done_valid;
    way_t done_way;

    modport master (
        output miss_valid, miss_set, miss_tag, fill_req_ready, fill_rsp_valid,
        input  miss_ready, fill_req_valid, fill_req_set, fill_req_tag,
               fill_req_way, done_valid, done_way
    );

    modport slave (
        input  miss_valid, miss_set, miss_tag, fill_req_ready, fill_rsp_valid,
        output miss_ready, fill_req_valid, fill_req_set, fill_req_tag,
               fill_req_way, done_valid, done_way
    );

endinterface
`default_nettype wire

// File: rtl/repl_policy.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | repl_policy                                                          |
// | Per-set replacement state. TAG_FILL_LRU_EN selects true LRU,         |
// | otherwise round-robin.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module repl_policy
    import cache_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic hit_valid,
    input  wire set_t hit_set,
    input  wire way_t hit_way,
    input  wire logic touch_valid,
    input  wire set_t touch_set,
    input  wire way_t touch_way,
    input  wire logic touch_victim,
    input  wire set_t victim_set,
    output way_t      victim_way
);

`ifdef TAG_FILL_LRU_EN
    age_vec_t r_age [N_SETS];
    age_vec_t w_next_age [N_SETS];

    // Out-of-range way indices leave the ages untouched.
    function automatic age_vec_t touch(input age_vec_t a, input way_t w);
        age_vec_t res = a;
        way_t     w_age = '0;
        logic     found = 1'b0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (way_t'(i) == w) begin
                w_age = a[i];
                found = 1'b1;
            end
        end
        if (found) begin
            for (int i = 0; i < N_WAYS; i++) begin
                if (way_t'(i) == w)
                    res[i] = '0;
                else if (a[i] < w_age)
                    res[i] = a[i] + 1'b1;
            end
        end
        return res;
    endfunction

    // Hit touch first so an allocating write to the same set ends MRU.
    always_comb begin
        for (int s = 0; s < N_SETS; s++) begin
            w_next_age[s] = r_age[s];
            if (hit_valid && hit_set == set_t'(s))
                w_next_age[s] = touch(w_next_age[s], hit_way);
            if (touch_valid && touch_set == set_t'(s))
                w_next_age[s] = touch(w_next_age[s], touch_way);
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < N_SETS; s++) begin
            if (rst) begin
                for (int i = 0; i < N_WAYS; i++)
                    r_age[s][i] <= way_t'(i);
            end else begin
                r_age[s] <= w_next_age[s];
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (r_age[victim_set][i] == way_t'(N_WAYS - 1))
                victim_way = way_t'(i);
        end
    end

    wire w_unused = &{1'b0, touch_victim};
`else
    way_t r_ptr [N_SETS];

    // The pointer only advances when a full set actually evicted its victim.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++)
                r_ptr[s] <= '0;
        end else if (touch_valid && touch_victim) begin
            r_ptr[touch_set] <= (r_ptr[touch_set] == way_t'(N_WAYS - 1))
                              ? '0 : r_ptr[touch_set] + 1'b1;
        end
    end

    assign victim_way = r_ptr[victim_set];

    wire w_unused = &{1'b0, hit_valid, hit_set, hit_way, touch_way};
`endif

endmodule
`default_nettype wire

// File: rtl/tag_fill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tag_fill_ctrl                                                        |
// | Tag/valid store, victim selection and line-fill handshake on miss.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tag_fill_ctrl
    import cache_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire set_t                rd_set,
    output tag_t [N_WAYS-1:0]        rd_tags,
    output logic [N_WAYS-1:0]        rd_empty,
    input  wire logic                hit_valid,
    input  wire set_t                hit_set,
    input  wire way_t                hit_way,
    input  wire logic                flush,
    tag_fill_ctrl_if.slave           bus
);

    state_t                r_state;
    state_t                w_next_state;
    set_t                  r_set;
    tag_t                  r_tag;
    way_t                  r_way;
    logic                  r_victim;
    tag_t [N_WAYS-1:0]     r_tags  [N_SETS];
    logic [N_WAYS-1:0]     r_valid [N_SETS];

    logic                  w_accept;
    logic                  w_flush_now;
    logic [N_WAYS-1:0]     w_row_valid;
    tag_t [N_WAYS-1:0]     w_row_tags;
    logic                  w_dup;
    way_t                  w_dup_way;
    logic                  w_has_empty;
    way_t                  w_empty_way;
    way_t                  w_policy_way;

    assign rd_tags  = r_tags[rd_set];
    assign rd_empty = ~r_valid[rd_set];

    assign w_row_valid = r_valid[bus.miss_set];
    assign w_row_tags  = r_tags[bus.miss_set];

    // First match wins for both the duplicate search and the empty search.
    always_comb begin
        w_dup       = 1'b0;
        w_dup_way   = '0;
        w_has_empty = 1'b0;
        w_empty_way = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (w_row_valid[i] && w_row_tags[i] == bus.miss_tag && !w_dup) begin
                w_dup     = 1'b1;
                w_dup_way = way_t'(i);
            end
            if (!w_row_valid[i] && !w_has_empty) begin
                w_has_empty = 1'b1;
                w_empty_way = way_t'(i);
            end
        end
    end

    repl_policy u_policy (
        .clk          (clk),
        .rst          (rst),
        .hit_valid    (hit_valid),
        .hit_set      (hit_set),
        .hit_way      (hit_way),
        .touch_valid  (r_state == WRITE),
        .touch_set    (r_set),
        .touch_way    (r_way),
        .touch_victim (r_victim),
        .victim_set   (bus.miss_set),
        .victim_way   (w_policy_way)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state       = r_state;
        w_accept           = 1'b0;
        w_flush_now        = 1'b0;
        bus.miss_ready     = 1'b0;
        bus.fill_req_valid = 1'b0;
        bus.done_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.miss_ready = ~flush;
                w_flush_now    = flush;
                if (bus.miss_valid && !flush) begin
                    w_accept     = 1'b1;
                    w_next_state = w_dup ? WRITE : REQ;
                end
            end
            REQ: begin
                bus.fill_req_valid = 1'b1;
                if (bus.fill_req_ready)
                    w_next_state = WAIT;
            end
            WAIT: begin
                if (bus.fill_rsp_valid)
                    w_next_state = WRITE;
            end
            WRITE: begin
                bus.done_valid = 1'b1;
                w_next_state   = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.fill_req_set = r_set;
    assign bus.fill_req_tag = r_tag;
    assign bus.fill_req_way = r_way;
    assign bus.done_way     = r_way;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_set    <= '0;
            r_tag    <= '0;
            r_way    <= '0;
            r_victim <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                r_tags[s]  <= '0;
                r_valid[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_set    <= bus.miss_set;
                r_tag    <= bus.miss_tag;
                r_way    <= w_dup ? w_dup_way
                          : (w_has_empty ? w_empty_way : w_policy_way);
                r_victim <= !w_dup && !w_has_empty;
            end
            if (r_state == WRITE) begin
                for (int i = 0; i < N_WAYS; i++) begin
                    if (r_way == way_t'(i)) begin
                        r_tags[r_set][i]  <= r_tag;
                        r_valid[r_set][i] <= 1'b1;
                    end
                end
            end
            // Flush only happens in IDLE, so it never races the WRITE update.
            if (w_flush_now) begin
                for (int s = 0; s < N_SETS; s++)
                    r_valid[s] <= '0;
            end
        end
    end

endmodule
`default_nettype wire
